hex_image_dumper: RTL and testbench

- Walks a window of the 256x16 instruction/data memory and serialises each word as ASCII hex text, one word per line: four hex digits, MSB nibble first, then LF (0x0A).
- Output is the same text image format the memory image loader consumes, so a dump can be fed straight back in as a reload image.
- Sits between the memory's synchronous read port and a byte-wide valid/ready character sink (UART TX FIFO or sim capture).

---
 rtl/hex_image_dumper.sv | 161 ++++++++++++++++
 tb/tb_hex_image_dumper.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_image_dumper.sv
// Streams a window of word memory to a byte sink as ASCII hex lines ("xxxx\n"), one read per word.
// Build macro HEXDUMP_ADDR_PREFIX_EN prefixes each line with the word address and ": ".
module hex_image_dumper #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int UPPER  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);
  localparam int NDIG  = DATA_W / 4;
  localparam int DIG_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {
    IDLE, FETCH, LATCH,
`ifdef HEXDUMP_ADDR_PREFIX_EN
    ADDR,
`endif
    DIGIT, EOL, FIN
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   remain_q, remain_d;
  logic [DIG_W-1:0]  dig_q, dig_d;
  logic [ADDR_W:0]   count_clamped;

`ifdef HEXDUMP_ADDR_PREFIX_EN
  localparam int ADIG   = (ADDR_W + 3) / 4;
  localparam int APOS_W = $clog2(ADIG + 2);
  logic [APOS_W-1:0] apos_q, apos_d;
  logic [ADIG*4-1:0] addr_pad;
  assign addr_pad = (ADIG*4)'(addr_q);
`endif

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return ((UPPER != 0) ? 8'h41 : 8'h61) + {4'h0, n} - 8'd10;
  endfunction

  assign count_clamped = (word_count > DEPTH) ? DEPTH : word_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      word_q   <= '0;
      addr_q   <= '0;
      remain_q <= '0;
      dig_q    <= '0;
`ifdef HEXDUMP_ADDR_PREFIX_EN
      apos_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      dig_q    <= dig_d;
`ifdef HEXDUMP_ADDR_PREFIX_EN
      apos_q   <= apos_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    dig_d    = dig_q;
`ifdef HEXDUMP_ADDR_PREFIX_EN
    apos_d   = apos_q;
`endif
    case (state_q)
      IDLE: if (start) begin
        addr_d   = base_addr;
        remain_d = count_clamped;
        state_d  = (count_clamped == '0) ? FIN : FETCH;
      end
      FETCH: state_d = LATCH;
      LATCH: begin
        word_d = mem_rdata;
        dig_d  = DIG_W'(NDIG - 1);
`ifdef HEXDUMP_ADDR_PREFIX_EN
        apos_d  = '0;
        state_d = ADDR;
`else
        state_d = DIGIT;
`endif
      end
`ifdef HEXDUMP_ADDR_PREFIX_EN
      ADDR: if (tx_ready) begin
        if (apos_q == APOS_W'(ADIG + 1)) state_d = DIGIT;
        else apos_d = apos_q + APOS_W'(1);
      end
`endif
      DIGIT: if (tx_ready) begin
        if (dig_q == '0) state_d = EOL;
        else dig_d = dig_q - DIG_W'(1);
      end
      EOL: if (tx_ready) begin
        remain_d = remain_q - (ADDR_W+1)'(1);
        // Compare before decrement: the line just sent was the last one.
        if (remain_q == (ADDR_W+1)'(1)) begin
          state_d = FIN;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = FETCH;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mem_addr = addr_q;

  always_comb begin
    busy      = (state_q != IDLE) && (state_q != FIN);
    done      = (state_q == FIN);
    mem_rd_en = (state_q == FETCH);
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    case (state_q)
`ifdef HEXDUMP_ADDR_PREFIX_EN
      ADDR: begin
        tx_valid = 1'b1;
        if (apos_q < APOS_W'(ADIG))
          tx_data = hex_char(addr_pad[(ADIG-1-int'(apos_q))*4 +: 4]);
        else if (apos_q == APOS_W'(ADIG))
          tx_data = 8'h3A;
        else
          tx_data = 8'h20;
      end
`endif
      DIGIT: begin
        tx_valid = 1'b1;
        tx_data  = hex_char(word_q[int'(dig_q)*4 +: 4]);
      end
      EOL: begin
        tx_valid = 1'b1;
        tx_data  = 8'h0A;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_hex_image_dumper.sv
// Self-checking bench for hex_image_dumper: memory model, negedge monitor, text-level reference model.
module tb_hex_image_dumper;
`ifdef HEXDUMP_ADDR_PREFIX_EN
  localparam int COST = 7 + 4;
`else
  localparam int COST = 7;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  base_addr = '0;
  logic [8:0]  word_count = '0;
  logic        busy, done, mem_rd_en, tx_valid;
  logic [7:0]  mem_addr, tx_data;
  logic [15:0] mem_rdata = '0;
  logic        tx_ready = 1'b1;

  hex_image_dumper #(.DATA_W(16), .ADDR_W(8), .UPPER(0)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_count(word_count),
    .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [256];
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] rd_q[$];
  int         done_q[$];
  int         first_vld = -1;
  bit         mon_en = 1'b0;
  bit         stall_prev = 1'b0;
  logic [7:0] stall_dat = '0;
  bit         rdy_rand = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (tx_valid && tx_ready) got_q.push_back(tx_data);
      if (mem_rd_en) rd_q.push_back(mem_addr);
      if (tx_valid && first_vld < 0) first_vld = cyc;
      if (done) done_q.push_back(cyc);
      if (stall_prev) begin
        n_chk++;
        if (!tx_valid || tx_data !== stall_dat) begin
          n_fail++;
          $display("FAIL stall_hold: valid=%0b data=%02h, required valid=1 data=%02h", tx_valid, tx_data, stall_dat);
        end
      end
      stall_prev = tx_valid && !tx_ready;
      stall_dat  = tx_data;
    end else begin
      stall_prev = 1'b0;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rdy_rand) tx_ready = ($urandom_range(0, 99) < 30);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required test completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    mon_en = 1'b0;
    got_q.delete();
    rd_q.delete();
    done_q.delete();
    first_vld = -1;
    mon_en = 1'b1;
  endtask

  task automatic pulse_start(input int b, input int c, output int s);
    base_addr  = 8'(b);
    word_count = 9'(c);
    start      = 1'b1;
    tick();
    s     = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done_q.size() > 0) break;
    end
    tick();
    tick();
  endtask

  // Expected text: one line per word of the (clamped, wrapping) window.
  task automatic build_exp(input int b, input int c);
    int    n;
    int    a;
    string s;
    exp_q.delete();
    n = (c > 256) ? 256 : c;
    for (int i = 0; i < n; i++) begin
      a = (b + i) % 256;
`ifdef HEXDUMP_ADDR_PREFIX_EN
      s = $sformatf("%02x: %04x\n", a, mem[a]);
`else
      s = $sformatf("%04x\n", mem[a]);
`endif
      for (int k = 0; k < s.len(); k++) exp_q.push_back(s[k]);
    end
  endtask

  function automatic int first_diff();
    int n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) return i;
    if (got_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    #3;
    n_chk++;
    if ({busy, done, mem_rd_en, tx_valid} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ctrl: busy/done/rd/valid=%b, required 0000", {busy, done, mem_rd_en, tx_valid});
    end
    n_chk++;
    if (tx_data !== 8'h00 || mem_addr !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_data: tx_data=%02h mem_addr=%02h, required 00 00", tx_data, mem_addr);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int s, d;
    mem[0] = 16'h1234; mem[1] = 16'hbeef; mem[2] = 16'h0000;
    build_exp(0, 3);
    clear_mon();
    pulse_start(0, 3, s);
    n_chk++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_rise: busy=%b, required 1", busy); end
    wait_done(200);
    d = first_diff();
    n_chk++;
    if (d >= 0) begin
      n_fail++;
      $display("FAIL basic_text: got %0d chars (diff at %0d), required %0d chars", got_q.size(), d, exp_q.size());
    end
    n_chk++;
    if (first_vld !== s + 2) begin
      n_fail++;
      $display("FAIL basic_first_valid: cycle %0d, required %0d", first_vld, s + 2);
    end
    n_chk++;
    if (done_q.size() != 1 || done_q[0] != s + 3 * COST) begin
      n_fail++;
      $display("FAIL basic_done: %0d pulses first at %0d, required 1 at %0d", done_q.size(),
               (done_q.size() > 0) ? done_q[0] : -1, s + 3 * COST);
    end
    n_chk++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_fall: busy=%b, required 0", busy); end
  endtask

  task automatic test_wrap();
    int s, d;
    mem[8'hFE] = 16'h00A1; mem[8'hFF] = 16'hFFFF; mem[8'h00] = 16'h8000;
    build_exp(8'hFE, 3);
    clear_mon();
    pulse_start(8'hFE, 3, s);
    wait_done(200);
    d = first_diff();
    n_chk++;
    if (d >= 0) begin
      n_fail++;
      $display("FAIL wrap_text: got %0d chars (diff at %0d), required %0d chars", got_q.size(), d, exp_q.size());
    end
    n_chk++;
    if (rd_q.size() != 3 || rd_q[0] !== 8'hFE || rd_q[1] !== 8'hFF || rd_q[2] !== 8'h00) begin
      n_fail++;
      $display("FAIL wrap_addrs: %0d reads first %02h, required FE FF 00", rd_q.size(),
               (rd_q.size() > 0) ? rd_q[0] : 8'hxx);
    end
  endtask

  task automatic test_backpressure();
    int s, d, b;
    b = $urandom_range(0, 255);
    for (int i = 0; i < 4; i++) mem[(b + i) % 256] = 16'($urandom);
    mem[b] = 16'h5A5A;
    build_exp(b, 4);
    clear_mon();
    rdy_rand = 1'b1;
    pulse_start(b, 4, s);
    wait_done(3000);
    rdy_rand = 1'b0;
    tx_ready = 1'b1;
    d = first_diff();
    n_chk++;
    if (d >= 0) begin
      n_fail++;
      $display("FAIL bp_text: got %0d chars (diff at %0d), required %0d chars", got_q.size(), d, exp_q.size());
    end
    n_chk++;
    if (rd_q.size() != 4) begin
      n_fail++;
      $display("FAIL bp_reads: %0d reads, required 4", rd_q.size());
    end
  endtask

  task automatic test_zero();
    int s;
    clear_mon();
    pulse_start(8'h40, 0, s);
    wait_done(50);
    n_chk++;
    if (got_q.size() != 0 || first_vld != -1 || rd_q.size() != 0) begin
      n_fail++;
      $display("FAIL zero_quiet: chars=%0d first_valid=%0d reads=%0d, required 0 -1 0",
               got_q.size(), first_vld, rd_q.size());
    end
    n_chk++;
    if (done_q.size() != 1 || done_q[0] != s) begin
      n_fail++;
      $display("FAIL zero_done: %0d pulses first at %0d, required 1 at %0d", done_q.size(),
               (done_q.size() > 0) ? done_q[0] : -1, s);
    end
  endtask

  task automatic test_clamp();
    int s, d, b, lines;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    b = $urandom_range(0, 255);
    build_exp(b, 300);
    clear_mon();
    pulse_start(b, 300, s);
    wait_done(256 * COST + 50);
    lines = 0;
    foreach (got_q[i]) if (got_q[i] == 8'h0A) lines++;
    n_chk++;
    if (lines != 256) begin n_fail++; $display("FAIL clamp_lines: %0d lines, required 256", lines); end
    d = first_diff();
    n_chk++;
    if (d >= 0) begin
      n_fail++;
      $display("FAIL clamp_text: got %0d chars (diff at %0d), required %0d chars", got_q.size(), d, exp_q.size());
    end
  endtask

  task automatic test_ignore_start();
    int s, d;
    build_exp(8'h10, 2);
    clear_mon();
    pulse_start(8'h10, 2, s);
    repeat (4) tick();
    base_addr = 8'h80; word_count = 9'd1; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(200);
    d = first_diff();
    n_chk++;
    if (d >= 0 || rd_q.size() != 2 || rd_q[0] !== 8'h10 || rd_q[1] !== 8'h11) begin
      n_fail++;
      $display("FAIL busy_start_ignored: chars=%0d diff=%0d reads=%0d, required %0d chars, reads 10 11",
               got_q.size(), d, rd_q.size(), exp_q.size());
    end
    // Start sampled in the FIN cycle must not launch a new dump.
    clear_mon();
    pulse_start(8'h10, 1, s);
    while (cyc < s + COST) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    n_chk++;
    if (busy !== 1'b0 || rd_q.size() != 1 || done_q.size() != 1) begin
      n_fail++;
      $display("FAIL fin_start_ignored: busy=%b reads=%0d dones=%0d, required 0 1 1", busy, rd_q.size(), done_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int s, d;
    mem[8'h20] = 16'hC0DE; mem[8'h21] = 16'h7F01;
    clear_mon();
    pulse_start(8'h20, 2, s);
    while (cyc < s + 3) tick();
    n_chk++;
    if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre: tx_valid=%b, required 1", tx_valid); end
    mon_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if ({busy, done, mem_rd_en, tx_valid} !== 4'b0000 || tx_data !== 8'h00 || mem_addr !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_mid_async: ctrl=%b tx_data=%02h mem_addr=%02h, required 0000 00 00",
               {busy, done, mem_rd_en, tx_valid}, tx_data, mem_addr);
    end
    tick();
    rst = 1'b0;
    tick();
    n_chk++;
    if (tx_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_idle: tx_valid=%b busy=%b, required 0 0", tx_valid, busy);
    end
    build_exp(8'h20, 2);
    clear_mon();
    pulse_start(8'h20, 2, s);
    wait_done(200);
    d = first_diff();
    n_chk++;
    if (d >= 0) begin
      n_fail++;
      $display("FAIL rst_mid_redump: got %0d chars (diff at %0d), required %0d chars", got_q.size(), d, exp_q.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero();
    test_clamp();
    test_ignore_start();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
